// File: rtl/spi_cfg_master_if.sv
// Request/response bundle for spi_cfg_master.
// The client takes the master modport; the block takes the slave one.
interface spi_cfg_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (
    output req_valid, req_write,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid, req_write,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid,
    output rsp_rdata
  );
endinterface

// File: rtl/spi_cfg_master.sv
// SPI register-file master: 16-bit {rw,addr,data} frames, MSB first.
// Define SPI_CFG_READBACK_EN to sample poci_i and return read data.
module spi_cfg_master #(
  parameter int CLK_DIV  = 2,
  parameter int IDLE_GAP = 2
) (
  input  logic            clk,
  input  logic            rst,
  spi_cfg_master_if.slave bus,
  output logic            spi_clk_o,
  output logic            cs_o,
  output logic            pico_o,
  input  logic            poci_i,
  output logic            busy
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  localparam logic [7:0] DIV_LAST =
    8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST =
    8'(IDLE_GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [4:0]  bit_q;
  logic        sclk_q;
  logic [15:0] sh_q;
  logic        rsp_q;

  logic accept, tick, rise, fall, done;
  logic div_end, in_frame;

  assign div_end = cnt_q == DIV_LAST;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    tick    = 1'b0;
    rise    = 1'b0;
    fall    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        accept  = 1'b1;
        state_d = SETUP;
      end
      SETUP: if (div_end) begin
        tick    = 1'b1;
        rise    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (div_end) begin
        tick = 1'b1;
        unique case (1'b1)
          sclk_q:
            fall = 1'b1;
          !sclk_q && bit_q == 5'd16:
            state_d = HOLD;
          default:
            rise = 1'b1;
        endcase
      end
      HOLD: if (div_end) begin
        tick    = 1'b1;
        done    = 1'b1;
        state_d = GAP;
      end
      GAP: if (cnt_q == GAP_LAST)
        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      sclk_q <= 1'b0;
      sh_q   <= '0;
      rsp_q  <= 1'b0;
    end else begin
      rsp_q <= done;
      if (state_q == IDLE ||
          state_d != state_q || tick)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 8'd1;
      if (rise)      sclk_q <= 1'b1;
      else if (fall) sclk_q <= 1'b0;
      if (accept)    bit_q <= '0;
      else if (rise) bit_q <= bit_q + 5'd1;
      if (accept)
        sh_q <= {bus.req_write,
                 bus.req_addr,
                 bus.req_write ?
                   bus.req_wdata : 8'h00};
      else if (fall)
        sh_q <= {sh_q[14:0], 1'b0};
    end
  end

  // cs rises in the accepting cycle, so back-to-back
  // frames are deselected only for the GAP cycles.
  assign in_frame =
    state_q inside {SETUP, SHIFT, HOLD};
  assign cs_o = in_frame || (accept && !rst);
  assign pico_o = in_frame ? sh_q[15] :
    (accept && !rst && bus.req_write);
  assign spi_clk_o     = sclk_q;
  assign busy          = state_q != IDLE;
  assign bus.req_ready = state_q == IDLE && !rst;
  assign bus.rsp_valid = rsp_q;

`ifdef SPI_CFG_READBACK_EN
  logic       wr_q;
  logic [7:0] smp_q;
  logic [7:0] rdata_q;

  // bit_q 8..15 marks the falls after rises 8..15
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      smp_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept)
        wr_q <= bus.req_write;
      if (fall && bit_q[4:3] == 2'b01)
        smp_q <= {smp_q[6:0], poci_i};
      if (done)
        rdata_q <= wr_q ? 8'h00 : smp_q;
    end
  end

  assign bus.rsp_rdata = rdata_q;
`else
  logic unused_poci;
  assign unused_poci   = poci_i;
  assign bus.rsp_rdata = 8'h00;
`endif

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master with a behavioural SPI slave.
// dut0 runs CLK_DIV=2, dut1 runs CLK_DIV=1; both IDLE_GAP=2.
module tb_spi_cfg_master;

`ifdef SPI_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_cfg_master_if bus0 ();
  spi_cfg_master_if bus1 ();

  logic sck0, cs0, pico0, busy0;
  logic sck1, cs1, pico1, busy1;
  logic poci0 = 1'b0;
  logic poci1 = 1'b0;

  spi_cfg_master #(
    .CLK_DIV(2), .IDLE_GAP(2)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .spi_clk_o(sck0), .cs_o(cs0),
    .pico_o(pico0), .poci_i(poci0),
    .busy(busy0)
  );

  spi_cfg_master #(
    .CLK_DIV(1), .IDLE_GAP(2)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .spi_clk_o(sck1), .cs_o(cs1),
    .pico_o(pico1), .poci_i(poci1),
    .busy(busy1)
  );

  // Slave: cs rise clears it, samples pico on rises,
  // drives data bits after rises 8..15.
  int          rise0 = 0, rise1 = 0;
  logic [15:0] cap0 = '0, cap1 = '0;
  logic [7:0]  sd0 = '0, sd1 = '0;
  logic [2:0]  k0, k1;

  always @(posedge sck0 or posedge cs0) begin
    if (sck0 !== 1'b1) begin
      rise0 = 0;
      cap0  = '0;
      poci0 = 1'b0;
    end else begin
      rise0 = rise0 + 1;
      cap0  = {cap0[14:0], pico0};
      k0    = 3'(15 - rise0);
      poci0 = (rise0 >= 8 && rise0 <= 15) ?
        sd0[k0] : 1'b0;
    end
  end

  always @(posedge sck1 or posedge cs1) begin
    if (sck1 !== 1'b1) begin
      rise1 = 0;
      cap1  = '0;
      poci1 = 1'b0;
    end else begin
      rise1 = rise1 + 1;
      cap1  = {cap1[14:0], pico1};
      k1    = 3'(15 - rise1);
      poci1 = (rise1 >= 8 && rise1 <= 15) ?
        sd1[k1] : 1'b0;
    end
  end

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  sdata;
    logic [15:0] frame;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vt [6];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input vec_t v);
    bus0.req_valid = 1'b1;
    bus0.req_write = v.wr;
    bus0.req_addr  = v.addr;
    bus0.req_wdata = v.wdata;
    sd0            = v.sdata;
  endtask

  // Returns #1 after the accepting edge.
  task automatic accept0(output bit ok);
    int n = 0;
    while (bus0.req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    ok = bus0.req_ready === 1'b1;
    tick();
  endtask

  // Cycle 1 is the one that starts at the accepting edge.
  task automatic wait_rsp0(output int cyc);
    cyc = 1;
    while (bus0.rsp_valid !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_vec0(input vec_t v);
    bit ok;
    int cyc;
    req0(v);
    accept0(ok);
    chk("accept", 32'(ok), 1);
    bus0.req_valid = 1'b0;
    chk("cs_first", 32'(cs0), 1);
    chk("pico_b15", 32'(pico0), 32'(v.frame[15]));
    chk("busy", 32'(busy0), 1);
    wait_rsp0(cyc);
    chk("latency", cyc, 69);
    chk("frame", 32'(cap0), 32'(v.frame));
    chk("rises", rise0, 16);
    chk("rdata", 32'(bus0.rsp_rdata), 32'(v.rdata));
    chk("cs_gap", 32'(cs0), 0);
    tick();
    chk("rsp_width", 32'(bus0.rsp_valid), 0);
    chk("rdata_hold", 32'(bus0.rsp_rdata),
        32'(v.rdata));
  endtask

  initial begin
    bit   ok;
    int   cyc, n, nlow, tog;
    logic seen, prev;

    vt[0] = '{1'b1, 7'd1, 8'h2A, 8'h00,
              16'h812A, 8'h00};
    vt[1] = '{1'b0, 7'd4, 8'hEE, 8'h03,
              16'h0400, RB ? 8'h03 : 8'h00};
    vt[2] = '{1'b0, 7'd2, 8'h00, 8'hFF,
              16'h0200, RB ? 8'hFF : 8'h00};
    vt[3] = '{1'b1, 7'h7F, 8'hA5, 8'h5A,
              16'hFFA5, 8'h00};
    vt[4] = '{1'b0, 7'h55, 8'h11, 8'hC6,
              16'h5500, RB ? 8'hC6 : 8'h00};
    vt[5] = '{1'b1, 7'd0, 8'h00, 8'hFF,
              16'h8000, 8'h00};

    bus0.req_valid = 1'b0;
    bus0.req_write = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;
    bus1.req_valid = 1'b0;
    bus1.req_write = 1'b0;
    bus1.req_addr  = '0;
    bus1.req_wdata = '0;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ready", 32'(bus0.req_ready), 0);
    chk("rst_rsp", 32'(bus0.rsp_valid), 0);
    chk("rst_rdata", 32'(bus0.rsp_rdata), 0);
    chk("rst_sck", 32'(sck0), 0);
    chk("rst_cs", 32'(cs0), 0);
    chk("rst_pico", 32'(pico0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_ready1", 32'(bus1.req_ready), 0);
    rst = 1'b0;
    tick();
    chk("ready0", 32'(bus0.req_ready), 1);
    chk("ready1", 32'(bus1.req_ready), 1);

    for (int i = 0; i < 6; i++)
      run_vec0(vt[i]);

    // Held req_valid, two writes back to back.
    req0(vt[0]);
    accept0(ok);
    chk("b2b_acc", 32'(ok), 1);
    req0(vt[3]);
    wait_rsp0(cyc);
    chk("b2b_lat1", cyc, 69);
    chk("b2b_frame1", 32'(cap0), 32'(vt[0].frame));
    nlow = 0;
    while (cs0 === 1'b0 && nlow < 10) begin
      nlow++;
      tick();
    end
    chk("b2b_cs_low", nlow, 2);
    chk("b2b_ready", 32'(bus0.req_ready), 1);
    tick();
    bus0.req_valid = 1'b0;
    chk("b2b_busy", 32'(busy0), 1);
    wait_rsp0(cyc);
    chk("b2b_lat2", cyc, 69);
    chk("b2b_frame2", 32'(cap0), 32'(vt[3].frame));
    chk("b2b_rdata", 32'(bus0.rsp_rdata), 0);

    // Reset on the 5th rising spi clock edge.
    req0(vt[1]);
    accept0(ok);
    bus0.req_valid = 1'b0;
    n = 0;
    while (rise0 < 5 && n < 200) begin
      tick();
      n++;
    end
    chk("abort_rise", rise0, 5);
    rst = 1'b1;
    tick();
    chk("abort_cs", 32'(cs0), 0);
    chk("abort_sck", 32'(sck0), 0);
    chk("abort_busy", 32'(busy0), 0);
    chk("abort_ready", 32'(bus0.req_ready), 0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      seen = seen | bus0.rsp_valid;
      tick();
    end
    chk("abort_no_rsp", 32'(seen), 0);
    run_vec0(vt[0]);

    // CLK_DIV=1: write addr 11, data 1F.
    bus1.req_valid = 1'b1;
    bus1.req_write = 1'b1;
    bus1.req_addr  = 7'd11;
    bus1.req_wdata = 8'h1F;
    sd1            = 8'h77;
    n = 0;
    while (bus1.req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tick();
    bus1.req_valid = 1'b0;
    cyc  = 1;
    tog  = 0;
    prev = sck1;
    while (bus1.rsp_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
      if (sck1 !== prev) tog++;
      prev = sck1;
    end
    chk("d1_latency", cyc, 35);
    chk("d1_toggles", tog, 32);
    chk("d1_frame", 32'(cap1), 32'h8B1F);
    chk("d1_rdata", 32'(bus1.rsp_rdata), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
